systolic_array_ctrl: RTL
========================

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 SHALL have parameter width_p, default 32, data word width.
REQ-002 SHALL have parameter array_width_p, default 2, number of MAC columns (W).
REQ-003 SHALL have parameter array_height_p, default 2, number of MAC rows (H).
REQ-004 SHALL have parameter depth_p, default 2, inner matrix dimension (K, input steps per job).
REQ-005 SHALL have parameter drain_cycles_p, default 4, settle cycles after the last input step.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: ports clk_i and reset_i.
REQ-007 SHALL have ports, in order:
- clk_i in 1: clock.
- reset_i in 1: async active-high reset.
- en_i in 1: global enable.
- abort_i in 1: cancel the current job.
- valid_i in 1, ready_o out 1, data_i in width_p: operand stream.
- valid_o out 1, yumi_i in 1, data_o out width_p: result stream.
- row_o out width_p*H, row_valid_o out H, row_ready_i in H: MAC array row feed.
- col_o out width_p*W, col_valid_o out W, col_ready_i in W: MAC array column feed.
- z_i in width_p*H*W: MAC accumulators.
- array_clear_o out 1: one-cycle MAC array clear.
- busy_o out 1: state is not LOAD.

Function
REQ-008 SHALL implement states LOAD, DRAIN, OUTPUT, CLEAR.
REQ-009 SHALL drive data_i onto all row_o and col_o slices, and assert at most one valid bit, selected by consumer index c (0..H-1 rows, H..H+W-1 columns).
REQ-010 SHALL set ready_o = en_i & (state==LOAD) & ready of the consumer at c; valid to that consumer = valid_i & ready_o.
REQ-011 SHALL advance c on each accepted beat, wrap c to 0 after H+W-1, and increment step counter s on wrap.
REQ-012 SHALL transition LOAD->DRAIN on the beat that wraps c with s==depth_p-1, clearing c and s.
REQ-013 SHALL hold DRAIN for exactly drain_cycles_p enabled cycles AND until all row_ready_i/col_ready_i are high, then go to OUTPUT.
REQ-014 SHALL, in OUTPUT: valid_o=en_i; data_o=z_i slice at output index o (element r*W+col); yumi_i advances o; o wraps H*W-1 -> 0; the yumi of the last element goes to CLEAR.
REQ-015 SHALL assert array_clear_o for exactly one cycle in CLEAR, then go to LOAD.
REQ-016 SHALL produce no handshakes and no state/counter change while en_i=0; valid_o=ready_o=0.
REQ-017 SHALL ignore yumi_i outside OUTPUT and valid_i outside LOAD.
REQ-018 SHALL drive data_o='0 outside OUTPUT.
REQ-019 SHALL take the first back-to-back job beat in LOAD directly after CLEAR; no idle bubble beyond CLEAR.

Reset
REQ-020 SHALL on reset_i: state=LOAD, c=s=o=0, drain count=0; ready_o follows REQ-010; valid_o=0, array_clear_o=0, busy_o=0, all valid outputs 0.
REQ-021 SHALL treat reset mid-job as job discard; no partial result emitted.

Configuration
REQ-022 SHALL honour macro SYSTOLIC_ARRAY_CTRL_ABORT_EN.
- Defined: abort_i=1 with en_i=1 in any state moves to CLEAR next cycle, clears counters, and drops any result not yet yumi'd; abort wins over a simultaneous accept or yumi.
- Undefined: abort_i is ignored.

Structure
REQ-023 SHALL place state enum ctrl_state_e (one-hot, 4 bits) in shared package systolic_pkg.
REQ-024 SHALL instantiate sub-module wrap_counter (parameter max_p, en_i, clear_i, count_o, wrap_o) for c, s, o and drain count.

Verification
REQ-025 SHALL cover a 2x2 job, K=2, with mac_array attached: A=[[1,2],[3,4]], B=[[5,6],[7,8]] streamed per step as a-row-col then b-row-col -> data_o sequence 19, 22, 43, 50, then one array_clear_o pulse.
REQ-026 SHALL cover yumi_i held low 10 cycles in OUTPUT -> valid_o stays 1, data_o stable at 19, no advance.
REQ-027 SHALL cover col_ready_i[0]=0 when c=2 -> ready_o=0, c holds; release -> beat accepted into column 0.
REQ-028 SHALL cover en_i=0 for 3 cycles mid-DRAIN -> DRAIN lasts drain_cycles_p+3 cycles.
REQ-029 SHALL cover abort_i during OUTPUT after 2 yumis, macro defined -> CLEAR next cycle, then LOAD; a new job yields correct results.
REQ-030 SHALL cover a 3x2 job (H=3, W=2, K=3) -> 5 beats per step, 15 beats total, 6 outputs in row-major order.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array controller and its counters.
package systolic_pkg;

  typedef enum logic [3:0] {
    ST_LOAD   = 4'b0001,
    ST_DRAIN  = 4'b0010,
    ST_OUTPUT = 4'b0100,
    ST_CLEAR  = 4'b1000
  } ctrl_state_e;

  // Bits needed to hold the values 0..max_v (never less than one bit).
  function automatic int cnt_width(input int max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_wrap_counter.sv
// Counter that runs 0..max_p and wraps back to 0; wrap_o flags the enabled wrapping step.
module wrap_counter
  import systolic_pkg::*;
#(
  parameter int max_p = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic                         clear_i,
  output logic [cnt_width(max_p)-1:0]  count_o,
  output logic                         wrap_o
);

  localparam int cw_lp = cnt_width(max_p);
  localparam logic [cw_lp-1:0] max_lp = cw_lp'(max_p);

  logic [cw_lp-1:0] count_q, count_d;

  assign wrap_o  = en_i & ~clear_i & (count_q == max_lp);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i || wrap_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a MAC array: loads operands, waits for drain, streams results, clears.
// Optional abort support is enabled by defining SYSTOLIC_ARRAY_CTRL_ABORT_EN.
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 2,
  parameter int drain_cycles_p = 4
) (
  input  logic                                            clk_i,
  input  logic                                            reset_i,
  input  logic                                            en_i,
  input  logic                                            abort_i,
  input  logic                                            valid_i,
  output logic                                            ready_o,
  input  logic [width_p-1:0]                              data_i,
  output logic                                            valid_o,
  input  logic                                            yumi_i,
  output logic [width_p-1:0]                              data_o,
  output logic [width_p*array_height_p-1:0]               row_o,
  output logic [array_height_p-1:0]                       row_valid_o,
  input  logic [array_height_p-1:0]                       row_ready_i,
  output logic [width_p*array_width_p-1:0]                col_o,
  output logic [array_width_p-1:0]                        col_valid_o,
  input  logic [array_width_p-1:0]                        col_ready_i,
  input  logic [width_p*array_height_p*array_width_p-1:0] z_i,
  output logic                                            array_clear_o,
  output logic                                            busy_o
);

  localparam int h_lp      = array_height_p;
  localparam int w_lp      = array_width_p;
  localparam int n_cons_lp = h_lp + w_lp;
  localparam int n_out_lp  = h_lp * w_lp;
  localparam int c_w_lp    = cnt_width(n_cons_lp - 1);
  localparam int s_w_lp    = cnt_width(depth_p - 1);
  localparam int o_w_lp    = cnt_width(n_out_lp - 1);
  localparam int d_w_lp    = cnt_width(drain_cycles_p - 1);
  localparam logic [d_w_lp-1:0] d_max_lp = d_w_lp'(drain_cycles_p - 1);

  // Handshake rule for every stream here: a beat transfers in the cycle where
  // valid and ready (or valid_o and yumi_i) are both high; nothing else moves data.

  ctrl_state_e state_q, state_d;

  logic abort_act;
  logic [n_cons_lp-1:0] cons_ready_vec;
  logic cons_ready, all_ready, accept;
  logic [c_w_lp-1:0] c_count;
  logic [s_w_lp-1:0] s_count;
  logic [o_w_lp-1:0] o_count;
  logic [d_w_lp-1:0] d_count;
  logic c_wrap, s_wrap, o_wrap, d_wrap;
  logic d_en, o_en;

`ifdef SYSTOLIC_ARRAY_CTRL_ABORT_EN
  assign abort_act = en_i & abort_i;
`else
  logic unused_abort;
  assign unused_abort = abort_i;
  assign abort_act    = 1'b0;
`endif

  assign cons_ready_vec = {col_ready_i, row_ready_i};
  assign all_ready      = &cons_ready_vec;

  always_comb begin
    cons_ready = 1'b0;
    for (int i = 0; i < n_cons_lp; i++) begin
      if (c_count == c_w_lp'(i)) cons_ready = cons_ready_vec[i];
    end
  end

  assign accept = valid_i & ready_o;

  // The drain count parks on its last value until every consumer is ready.
  assign d_en = en_i & ~abort_act & (state_q == ST_DRAIN) &
                ((d_count != d_max_lp) | all_ready);
  assign o_en = en_i & ~abort_act & (state_q == ST_OUTPUT) & yumi_i;

  wrap_counter #(.max_p(n_cons_lp - 1)) u_c_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(accept), .clear_i(abort_act),
    .count_o(c_count), .wrap_o(c_wrap)
  );

  wrap_counter #(.max_p(depth_p - 1)) u_s_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(accept & c_wrap), .clear_i(abort_act),
    .count_o(s_count), .wrap_o(s_wrap)
  );

  wrap_counter #(.max_p(n_out_lp - 1)) u_o_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(o_en), .clear_i(abort_act),
    .count_o(o_count), .wrap_o(o_wrap)
  );

  wrap_counter #(.max_p(drain_cycles_p - 1)) u_d_cnt (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(d_en), .clear_i(abort_act),
    .count_o(d_count), .wrap_o(d_wrap)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_act) begin
      state_d = ST_CLEAR;
    end else if (en_i) begin
      case (state_q)
        ST_LOAD:   if (s_wrap) state_d = ST_DRAIN;
        ST_DRAIN:  if (d_wrap) state_d = ST_OUTPUT;
        ST_OUTPUT: if (o_wrap) state_d = ST_CLEAR;
        ST_CLEAR:  state_d = ST_LOAD;
        default:   state_d = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    ready_o       = en_i & ~abort_act & (state_q == ST_LOAD) & cons_ready;
    valid_o       = en_i & ~abort_act & (state_q == ST_OUTPUT);
    array_clear_o = en_i & (state_q == ST_CLEAR);
    busy_o        = (state_q != ST_LOAD);
    data_o        = '0;
    if (state_q == ST_OUTPUT) begin
      for (int k = 0; k < n_out_lp; k++) begin
        if (o_count == o_w_lp'(k)) data_o = z_i[k*width_p +: width_p];
      end
    end
  end

  assign row_o = {array_height_p{data_i}};
  assign col_o = {array_width_p{data_i}};

  always_comb begin
    row_valid_o = '0;
    col_valid_o = '0;
    for (int i = 0; i < h_lp; i++) begin
      if (c_count == c_w_lp'(i)) row_valid_o[i] = accept;
    end
    for (int j = 0; j < w_lp; j++) begin
      if (c_count == c_w_lp'(h_lp + j)) col_valid_o[j] = accept;
    end
  end

  logic unused_s;
  assign unused_s = ^s_count;

endmodule
